// File: rtl/pio_read_arbiter.sv
// Round-robin arbiter sharing one registered-read PIO port between NUM_REQ
// requesters and a periodic poller that shadows PIO word 0.
module pio_read_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int POLL_PERIOD = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]     ack,
    output logic [31:0]            rdata,
    output logic [1:0]             pio_address,
    input  logic [31:0]            pio_readdata,
    output logic [31:0]            poll_value,
    output logic                   poll_change,
    output logic                   busy
);

    localparam int NSLOT = NUM_REQ + 1;
    localparam int PTR_W = $clog2(NSLOT);
    localparam logic [PTR_W-1:0] POLL_SLOT = PTR_W'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ADDR, CAPT, RESP} state_e;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [1:0]       addr_q, addr_d;
    logic [31:0]      rdata_q, poll_value_q;
    logic             poll_change_q, poll_valid_q, poll_pend_q;

    logic [NSLOT-1:0] slot_req;
    logic             grant_vld;
    logic [PTR_W-1:0] grant_idx;
    logic [1:0]       grant_addr;
    logic             win_is_poll;

    assign slot_req    = {poll_pend_q, req};
    assign win_is_poll = (win_q == POLL_SLOT);

    // First requesting slot at or after the pointer, wrapping over NSLOT slots.
    always_comb begin
        logic [PTR_W:0] s;
        grant_vld = 1'b0;
        grant_idx = '0;
        s         = '0;
        for (int k = 0; k < NSLOT; k++) begin
            s = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (s >= (PTR_W+1)'(NSLOT)) s = s - (PTR_W+1)'(NSLOT);
            if (!grant_vld && slot_req[s[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = s[PTR_W-1:0];
            end
        end
    end

    // The poll slot matches no requester index, so it reads address 0.
    always_comb begin
        grant_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) grant_addr = req_addr[2*i +: 2];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    state_d = ADDR;
                    win_d   = grant_idx;
                    addr_d  = grant_addr;
                    ptr_d   = (grant_idx == POLL_SLOT) ? '0 : grant_idx + PTR_W'(1);
                end
            end
            ADDR:    state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            addr_q  <= addr_d;
        end
    end

    // Capture lands at the end of CAPT so data and poll flags are visible in RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q       <= '0;
            poll_value_q  <= '0;
            poll_valid_q  <= 1'b0;
            poll_change_q <= 1'b0;
        end else begin
            poll_change_q <= 1'b0;
            if (state_q == CAPT) begin
                if (win_is_poll) begin
                    poll_value_q  <= pio_readdata;
                    poll_valid_q  <= 1'b1;
                    poll_change_q <= poll_valid_q && (pio_readdata != poll_value_q);
                end else begin
                    rdata_q <= pio_readdata;
                end
            end
        end
    end

    generate
        if (POLL_PERIOD > 0) begin : g_poll
            localparam int CNT_W = $clog2(POLL_PERIOD + 1);
            localparam logic [CNT_W-1:0] TMAX = CNT_W'(POLL_PERIOD - 1);
            logic [CNT_W-1:0] timer_q;
            logic             wrap;

            assign wrap = (timer_q == TMAX);

            // A wrap landing on the poll's own RESP re-arms the pending flag.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    timer_q     <= '0;
                    poll_pend_q <= 1'b0;
                end else begin
                    timer_q <= wrap ? '0 : timer_q + CNT_W'(1);
                    if (wrap)
                        poll_pend_q <= 1'b1;
                    else if (state_q == RESP && win_is_poll)
                        poll_pend_q <= 1'b0;
                end
            end
        end else begin : g_nopoll
            assign poll_pend_q = 1'b0;
        end
    endgenerate

    always_comb begin
        ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = (state_q == RESP) && (win_q == PTR_W'(i));
        end
    end

    assign busy        = (state_q != IDLE);
    assign pio_address = (state_q == ADDR || state_q == CAPT) ? addr_q : 2'b00;
    assign rdata       = rdata_q;
    assign poll_value  = poll_value_q;
    assign poll_change = poll_change_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Randomized bench: a transaction-level model predicts each access and a
// negedge monitor compares DUT outputs against the scoreboard queues.
module tb_pio_read_arbiter;

    localparam int NR = 2;
    localparam int PP = 10;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [2*NR-1:0] req_addr = '0;
    logic [NR-1:0]   ack;
    logic [31:0]     rdata;
    logic [1:0]      pio_address;
    logic [31:0]     pio_readdata = '0;
    logic [31:0]     poll_value;
    logic            poll_change;
    logic            busy;
    logic [31:0]     pio_mem [4];

    pio_read_arbiter #(.NUM_REQ(NR), .POLL_PERIOD(PP)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .ack(ack), .rdata(rdata), .pio_address(pio_address),
        .pio_readdata(pio_readdata), .poll_value(poll_value),
        .poll_change(poll_change), .busy(busy)
    );

    always #5 clk = ~clk;

    // PIO slave: readdata registered one cycle after the address.
    always @(posedge clk) pio_readdata <= pio_mem[pio_address];

    typedef struct { int cyc; int slot; logic [31:0] data; bit chg; } exp_t;
    typedef struct { int cyc; logic [1:0] a; } aexp_t;

    exp_t  sb[$];
    aexp_t aq[$];
    int    checks = 0, failures = 0;

    // Reference model state: one access in flight at most.
    int          m_cyc = 0;
    bit          m_act = 0;
    int          m_T = 0, m_slot = 0, m_ptr = 0;
    logic [1:0]  m_addr = '0;
    bit          m_pend = 0, m_pvalid = 0;
    logic [31:0] m_pval = '0;
    int          busy_lo = 1, busy_hi = 0;
    logic [31:0] exp_rdata = '0, exp_pv = '0;

    bit freeze = 1'b0;
    int rate = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        aq.delete();
        m_cyc = 0; m_act = 0; m_ptr = 0; m_pend = 0; m_pvalid = 0; m_pval = '0;
        busy_lo = 1; busy_hi = 0;
        exp_rdata = '0; exp_pv = '0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pio_address", 32'(pio_address), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_poll_value", poll_value, 32'd0);
        chk("rst_poll_change", 32'(poll_change), 32'd0);
    endtask

    // Model: processes the cycle ending at this edge.
    always @(posedge clk) begin
        int c, w;
        bit found, chg;
        logic [31:0] d;
        logic [NR:0] sr;
        if (reset_n) begin
            c = m_cyc;
            if (m_act && c == m_T + 1) begin
                d = pio_mem[m_addr];
                chg = 0;
                if (m_slot == NR) begin
                    chg = m_pvalid && (d != m_pval);
                    m_pval = d;
                    m_pvalid = 1;
                end
                sb.push_back('{m_T + 3, m_slot, d, chg});
            end
            if (m_act && c == m_T + 3) begin
                if (m_slot == NR) m_pend = 0;
                m_act = 0;
            end else if (!m_act) begin
                sr = {m_pend, req};
                found = 0;
                w = 0;
                for (int k = 0; k <= NR; k++) begin
                    int s;
                    s = (m_ptr + k) % (NR + 1);
                    if (!found && sr[s]) begin found = 1; w = s; end
                end
                if (found) begin
                    m_act = 1; m_T = c; m_slot = w;
                    m_addr = (w == NR) ? 2'b00 : req_addr[2*w +: 2];
                    m_ptr = (w + 1) % (NR + 1);
                    aq.push_back('{c + 1, m_addr});
                    aq.push_back('{c + 2, m_addr});
                    busy_lo = c + 1;
                    busy_hi = c + 3;
                end
            end
            if ((c % PP) == PP - 1) m_pend = 1;
            m_cyc = c + 1;
        end
    end

    // Monitor: compare every cycle against scoreboard entries due now.
    always @(negedge clk) begin
        int c;
        logic [NR-1:0] ea;
        bit ec;
        logic [1:0] eaddr;
        exp_t e;
        aexp_t a;
        if (reset_n) begin
            c = m_cyc; ea = '0; ec = 0; eaddr = '0;
            if (sb.size() > 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                if (e.slot < NR) begin ea[e.slot] = 1'b1; exp_rdata = e.data; end
                else begin exp_pv = e.data; ec = e.chg; end
            end
            if (aq.size() > 0 && aq[0].cyc == c) begin
                a = aq.pop_front();
                eaddr = a.a;
            end
            chk("ack", 32'(ack), 32'(ea));
            chk("rdata", rdata, exp_rdata);
            chk("poll_value", poll_value, exp_pv);
            chk("poll_change", 32'(poll_change), 32'(ec));
            chk("busy", 32'(busy), 32'(c >= busy_lo && c <= busy_hi));
            chk("pio_address", 32'(pio_address), 32'(eaddr));
        end
    end

    // Requester agents and PIO word-0 drift.
    always @(negedge clk) begin
        if (!freeze) begin
            for (int i = 0; i < NR; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                    else req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
                end else if (!req[i]) begin
                    if (int'($urandom_range(0, 99)) < rate) begin
                        req[i] = 1'b1;
                        req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
                    end
                end else begin
                    if ($urandom_range(0, 15) == 0) req_addr[2*i +: 2] = 2'($urandom_range(0, 3));
                    if ($urandom_range(0, 39) == 0) req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 3) == 0) pio_mem[0] = $urandom;
                else pio_mem[0] = ($urandom_range(0, 1) != 0) ? 32'h5 : 32'h6;
            end
        end
    end

    initial begin
        bit hit;
        pio_mem[0] = 32'h5;
        pio_mem[1] = 32'h0;
        pio_mem[2] = 32'h1234_5678;
        pio_mem[3] = 32'hCAFE_F00D;
        model_clear();
        repeat (3) @(negedge clk);
        #1 chk_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        rate = 0;   repeat (60)  @(negedge clk);
        rate = 100; repeat (400) @(negedge clk);
        rate = 15;  repeat (400) @(negedge clk);

        // Reset while an access sits in CAPT, with req[0] held throughout.
        freeze = 1'b1;
        req[1] = 1'b0;
        req[0] = 1'b1;
        req_addr[1:0] = 2'b11;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            hit = m_act && (m_cyc == m_T + 2);
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL capt_wait: no CAPT cycle seen within 200 cycles");
        end
        reset_n = 1'b0;
        #1 chk_reset_outputs();
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        freeze = 1'b0;
        rate = 30;  repeat (400) @(negedge clk);

        freeze = 1'b1;
        req = '0;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
